fp_mac_adder: RTL

//   Pipelined IEEE-754 single-precision adder: the accumulate stage of the FP MAC.

---
 rtl/fp_mac_adder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mac_adder.sv
// fp_mac_adder: 4-stage pipelined FP32 adder forming the accumulate stage of the FP MAC.
// Denormals flush to zero, rounding is round-to-nearest-even, no backpressure.
// Define FP_MAC_ADD_FLAGS_EN to add the registered {invalid,overflow,underflow} flags port.
module fp_mac_adder #(
    parameter int LATENCY = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] product_data,
    input  logic [31:0] sum_in_data,
    output logic        out_valid,
    output logic [31:0] result_data
`ifdef FP_MAC_ADD_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic        sign;
        logic        eff_sub;
        logic [7:0]  exp_a;
        logic [22:0] man_a;
        logic [22:0] man_b;
        logic [7:0]  diff;
        logic        spec;
        logic [31:0] spec_res;
    } s1_t;

    typedef struct packed {
        logic        sign;
        logic        eff_sub;
        logic [7:0]  exp_a;
        logic [26:0] a_al;
        logic [26:0] b_al;
        logic        spec;
        logic [31:0] spec_res;
    } s2_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp_a;
        logic [27:0] sum;
        logic [4:0]  lzc;
        logic        spec;
        logic [31:0] spec_res;
    } s3_t;

    logic [LATENCY-1:0] vld_q, vld_d;
    s1_t                s1_q, s1_d;
    s2_t                s2_q, s2_d;
    s3_t                s3_q, s3_d;
    logic [31:0]        result_q, result_d;
`ifdef FP_MAC_ADD_FLAGS_EN
    logic [2:0]         flags_q, flags_d;
`endif

    // Leading-zero count of the 27-bit sum below the carry position (27 when all zero)
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Round-to-nearest-even on G/R/S, renormalise a rounding carry, saturate to Inf
    function automatic logic [31:0] round_pack(input logic sign, input logic signed [9:0] exp_in,
                                               input logic [26:0] norm);
        logic [24:0]       man;
        logic signed [9:0] e;
        logic              up;
        up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        man = {1'b0, norm[26:3]} + {24'd0, up};
        e   = exp_in;
        if (man[24]) begin
            man = man >> 1;
            e   = e + 10'sd1;
        end
        if (e >= 10'sd255) return {sign, 8'hFF, 23'd0};
        return {sign, e[7:0], man[22:0]};
    endfunction

    // Valid shift register: one bit per stage, always advancing
    always_comb begin
        vld_d = {vld_q[LATENCY-2:0], in_valid};
    end

    // S1: unpack, flush denormals, order operands by magnitude, resolve special operands
    always_comb begin
        logic        sa, sb, swap;
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb;
        logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        sa     = product_data[31];
        ea     = product_data[30:23];
        ma     = (ea == 8'd0) ? 23'd0 : product_data[22:0];
        sb     = sum_in_data[31];
        eb     = sum_in_data[30:23];
        mb     = (eb == 8'd0) ? 23'd0 : sum_in_data[22:0];
        nan_a  = (ea == 8'hFF) && (ma != 23'd0);
        nan_b  = (eb == 8'hFF) && (mb != 23'd0);
        inf_a  = (ea == 8'hFF) && (ma == 23'd0);
        inf_b  = (eb == 8'hFF) && (mb == 23'd0);
        zero_a = (ea == 8'd0);
        zero_b = (eb == 8'd0);
        swap   = {eb, mb} > {ea, ma};
        s1_d   = s1_q;
        if (in_valid) begin
            s1_d.sign     = swap ? sb : sa;
            s1_d.eff_sub  = sa ^ sb;
            s1_d.exp_a    = swap ? eb : ea;
            s1_d.man_a    = swap ? mb : ma;
            s1_d.man_b    = swap ? ma : mb;
            s1_d.diff     = swap ? (eb - ea) : (ea - eb);
            s1_d.spec     = 1'b1;
            if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) s1_d.spec_res = QNAN;
            else if (inf_a)             s1_d.spec_res = {sa, 8'hFF, 23'd0};
            else if (inf_b)             s1_d.spec_res = {sb, 8'hFF, 23'd0};
            else if (zero_a && zero_b)  s1_d.spec_res = {sa & sb, 31'd0};
            else if (zero_a)            s1_d.spec_res = {sb, eb, mb};
            else if (zero_b)            s1_d.spec_res = {sa, ea, ma};
            else begin
                s1_d.spec     = 1'b0;
                s1_d.spec_res = 32'd0;
            end
        end
    end

    // S2: build hidden-1 significands with G/R/S and align B, folding lost bits into sticky
    always_comb begin
        logic [26:0] b_ext, b_sh, lost_mask;
        b_ext     = {1'b1, s1_q.man_b, 3'b000};
        b_sh      = b_ext >> s1_q.diff;
        lost_mask = (27'd1 << s1_q.diff) - 27'd1;
        s2_d      = s2_q;
        if (vld_q[0]) begin
            s2_d.sign     = s1_q.sign;
            s2_d.eff_sub  = s1_q.eff_sub;
            s2_d.exp_a    = s1_q.exp_a;
            s2_d.a_al     = {1'b1, s1_q.man_a, 3'b000};
            s2_d.spec     = s1_q.spec;
            s2_d.spec_res = s1_q.spec_res;
            if (s1_q.diff >= 8'd26) s2_d.b_al = 27'd1;
            else s2_d.b_al = {b_sh[26:1], b_sh[0] | (|(b_ext & lost_mask))};
        end
    end

    // S3: magnitude add or subtract (A-B never goes negative) and leading-zero count
    always_comb begin
        logic [27:0] sum;
        sum  = s2_q.eff_sub ? ({1'b0, s2_q.a_al} - {1'b0, s2_q.b_al})
                            : ({1'b0, s2_q.a_al} + {1'b0, s2_q.b_al});
        s3_d = s3_q;
        if (vld_q[1]) begin
            s3_d.sign     = s2_q.sign;
            s3_d.exp_a    = s2_q.exp_a;
            s3_d.sum      = sum;
            s3_d.lzc      = lzc27(sum[26:0]);
            s3_d.spec     = s2_q.spec;
            s3_d.spec_res = s2_q.spec_res;
        end
    end

    // S4: normalise, round and pack, or pass the bypassed special result through
    always_comb begin
        logic [26:0]       norm;
        logic signed [9:0] exp_n;
        logic [31:0]       res;
        norm  = '0;
        exp_n = '0;
        if (s3_q.spec) begin
            res = s3_q.spec_res;
        end else if (s3_q.sum == 28'd0) begin
            res = 32'd0;
        end else begin
            if (s3_q.sum[27]) begin
                norm  = {s3_q.sum[27:2], s3_q.sum[1] | s3_q.sum[0]};
                exp_n = $signed({2'b00, s3_q.exp_a}) + 10'sd1;
            end else begin
                norm  = s3_q.sum[26:0] << s3_q.lzc;
                exp_n = $signed({2'b00, s3_q.exp_a}) - $signed({5'd0, s3_q.lzc});
            end
            if (exp_n <= 10'sd0) res = {s3_q.sign, 31'd0};
            else res = round_pack(s3_q.sign, exp_n, norm);
        end
        result_d = result_q;
        if (vld_q[2]) result_d = res;
`ifdef FP_MAC_ADD_FLAGS_EN
        flags_d = flags_q;
        if (vld_q[2]) begin
            flags_d = {s3_q.spec && (s3_q.spec_res == QNAN),
                       !s3_q.spec && (s3_q.sum != 28'd0) && (exp_n > 10'sd0) && (res[30:23] == 8'hFF),
                       !s3_q.spec && (s3_q.sum != 28'd0) && (exp_n <= 10'sd0)};
        end
`endif
    end

    // Pipeline and output registers; all clear on reset so nothing in flight survives
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_q    <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            result_q <= '0;
`ifdef FP_MAC_ADD_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            vld_q    <= vld_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            result_q <= result_d;
`ifdef FP_MAC_ADD_FLAGS_EN
            flags_q  <= flags_d;
`endif
        end
    end

    assign out_valid   = vld_q[LATENCY-1];
    assign result_data = result_q;
`ifdef FP_MAC_ADD_FLAGS_EN
    assign flags       = flags_q;
`endif

endmodule
